// File: rtl/pool_layer_pkg.sv
// Shared conv/pool package: datapath widths, the channel-vector type and the
// row-parity FSM states used by the pooling stage.
package pool_layer_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int NUM_KERNEL = 6;
    localparam int BUS_WIDTH  = DATA_WIDTH * NUM_KERNEL;

    typedef logic signed [DATA_WIDTH-1:0] chan_t;
    typedef logic [BUS_WIDTH-1:0]         chan_vec_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        EVEN_ROW = 2'd1,
        ODD_ROW  = 2'd2
    } pool_state_t;

endpackage

// File: rtl/pool_layer_max_cmp.sv
// Combinational signed two-input maximum for one channel lane.
module max_cmp
    import pool_layer_pkg::*;
(
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic [DATA_WIDTH-1:0] y
);

    assign y = ($signed(a) >= $signed(b)) ? a : b;

endmodule

// File: rtl/pool_layer_top.sv
// 2x2 stride-2 max pooling over a raster-order stream of six-channel pixels.
// Even rows fold pixel pairs into a half-width line buffer; odd rows emit.
module pool_layer_top
    import pool_layer_pkg::*;
#(
    parameter int FMAP_WIDTH  = 14,
    parameter int FMAP_HEIGHT = 14
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic                 i_valid,
    input  logic [BUS_WIDTH-1:0] i_pixel_bus,
    output logic                 o_valid,
    output logic [BUS_WIDTH-1:0] o_pixel_bus,
    output logic                 o_frame_done
);

    localparam int COL_W    = $clog2(FMAP_WIDTH);
    localparam int ROW_W    = $clog2(FMAP_HEIGHT);
    localparam int LB_DEPTH = FMAP_WIDTH / 2;
    localparam int LB_AW    = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;

    pool_state_t      state;
    pool_state_t      next_state;
    logic [COL_W-1:0] col;
    logic [COL_W-1:0] col_next;
    logic [ROW_W-1:0] row;
    logic [ROW_W-1:0] row_next;
    logic [LB_AW-1:0] lb_idx;

    logic      accept;
    logic      odd_col;
    logic      col_wrap;
    logic      row_wrap;
    chan_vec_t pair_reg;
    chan_vec_t stage1;
    chan_vec_t stage2;
    chan_vec_t lb_rd;
    chan_vec_t line_buf [LB_DEPTH];

    assign accept   = enable && i_valid;
    assign odd_col  = col[0];
    assign col_wrap = (col == COL_W'(FMAP_WIDTH - 1));
    assign row_wrap = (row == ROW_W'(FMAP_HEIGHT - 1));
    assign lb_idx   = LB_AW'(col >> 1);
    assign lb_rd    = line_buf[lb_idx];

    for (genvar k = 0; k < NUM_KERNEL; k++) begin : g_lane
        localparam int LO = (NUM_KERNEL - 1 - k) * DATA_WIDTH;

        max_cmp u_pair_max (
            .a (pair_reg[LO +: DATA_WIDTH]),
            .b (i_pixel_bus[LO +: DATA_WIDTH]),
            .y (stage1[LO +: DATA_WIDTH])
        );

        max_cmp u_window_max (
            .a (stage1[LO +: DATA_WIDTH]),
            .b (lb_rd[LO +: DATA_WIDTH]),
            .y (stage2[LO +: DATA_WIDTH])
        );
    end

    // The FSM only tracks row parity; IDLE behaves as an even row for its first beat.
    always_comb begin
        next_state = state;
        col_next   = col;
        row_next   = row;
        if (!enable) begin
            next_state = IDLE;
            col_next   = '0;
            row_next   = '0;
        end else if (accept) begin
            col_next = col_wrap ? '0 : col + COL_W'(1);
            if (col_wrap) begin
                row_next = row_wrap ? '0 : row + ROW_W'(1);
            end
            case (state)
                IDLE:     next_state = EVEN_ROW;
                EVEN_ROW: if (col_wrap) next_state = ODD_ROW;
                ODD_ROW:  if (col_wrap) next_state = EVEN_ROW;
                default:  next_state = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            col   <= '0;
            row   <= '0;
        end else begin
            state <= next_state;
            col   <= col_next;
            row   <= row_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pair_reg <= '0;
        end else if (accept && !odd_col) begin
            pair_reg <= i_pixel_bus;
        end
    end

    // Line buffer needs no reset: every entry is rewritten on an even row before it is read.
    always_ff @(posedge clk) begin
        if (accept && odd_col && (state != ODD_ROW)) begin
            line_buf[lb_idx] <= stage1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_valid      <= 1'b0;
            o_frame_done <= 1'b0;
            o_pixel_bus  <= '0;
        end else begin
            o_valid      <= 1'b0;
            o_frame_done <= 1'b0;
            if (accept && odd_col && (state == ODD_ROW)) begin
                o_valid      <= 1'b1;
                o_pixel_bus  <= stage2;
                o_frame_done <= col_wrap && row_wrap;
            end
        end
    end

endmodule

// File: tb/tb_pool_layer_top.sv
// Self-checking bench: a 2x2 instance for table-driven window vectors, a 4x4
// instance for ramp/soft-clear/back-to-back frames and a 14x14 instance for gaps/reset.
module tb_pool_layer_top;
    import pool_layer_pkg::*;

    localparam int BW = BUS_WIDTH;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          enable;
    logic          i_valid;
    logic [BW-1:0] i_pixel_bus;

    logic          o2_valid, o2_fd, o4_valid, o4_fd, o14_valid, o14_fd;
    logic [BW-1:0] o2_px, o4_px, o14_px;

    always #5 clk = ~clk;

    pool_layer_top #(.FMAP_WIDTH(2), .FMAP_HEIGHT(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .enable(enable), .i_valid(i_valid),
        .i_pixel_bus(i_pixel_bus), .o_valid(o2_valid), .o_pixel_bus(o2_px),
        .o_frame_done(o2_fd)
    );

    pool_layer_top #(.FMAP_WIDTH(4), .FMAP_HEIGHT(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .enable(enable), .i_valid(i_valid),
        .i_pixel_bus(i_pixel_bus), .o_valid(o4_valid), .o_pixel_bus(o4_px),
        .o_frame_done(o4_fd)
    );

    pool_layer_top #(.FMAP_WIDTH(14), .FMAP_HEIGHT(14)) u_dut14 (
        .clk(clk), .rst_n(rst_n), .enable(enable), .i_valid(i_valid),
        .i_pixel_bus(i_pixel_bus), .o_valid(o14_valid), .o_pixel_bus(o14_px),
        .o_frame_done(o14_fd)
    );

    typedef struct packed {
        logic [BW-1:0] bus;
        logic          fd;
    } exp_t;

    typedef struct packed {
        int p0;
        int p1;
        int p2;
        int p3;
        int step;
        int exp_max;
    } vec_t;

    exp_t exp_q[$];
    vec_t tbl[8];
    int   checks  = 0;
    int   errors  = 0;
    int   mon_sel = 0;
    int   n_out   = 0;
    int   n_fd    = 0;

    // Lane k carries base + k*step; channel 0 sits in the top 32 bits.
    function automatic logic [BW-1:0] lanes(int base, int step);
        logic [BW-1:0] b;
        b = '0;
        for (int k = 0; k < NUM_KERNEL; k++) begin
            b[(NUM_KERNEL-1-k)*DATA_WIDTH +: DATA_WIDTH] = 32'(base + k * step);
        end
        return b;
    endfunction

    // 14x14 pattern: even lanes rise along the raster, odd lanes fall.
    function automatic logic [BW-1:0] bus14(int r, int c);
        logic [BW-1:0] b;
        int v;
        b = '0;
        v = r * 14 + c;
        for (int k = 0; k < NUM_KERNEL; k++) begin
            b[(NUM_KERNEL-1-k)*DATA_WIDTH +: DATA_WIDTH] =
                32'(((k % 2) == 1) ? (-v + k * 1000) : (v + k * 1000));
        end
        return b;
    endfunction

    // Window ending at (r,c): rising lanes peak bottom-right, falling lanes top-left.
    function automatic logic [BW-1:0] exp14(int r, int c);
        logic [BW-1:0] b;
        b = '0;
        for (int k = 0; k < NUM_KERNEL; k++) begin
            b[(NUM_KERNEL-1-k)*DATA_WIDTH +: DATA_WIDTH] =
                32'(((k % 2) == 1) ? (-((r - 1) * 14 + (c - 1)) + k * 1000)
                                   : (r * 14 + c + k * 1000));
        end
        return b;
    endfunction

    task automatic checkOutput(string name, logic [BW-1:0] act, logic [BW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic checkNum(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s: actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Each call waits for a falling edge, scores the monitored DUT, then drives the next beat.
    task automatic applyStimulus(logic en, logic v, logic [BW-1:0] bus);
        exp_t          e;
        logic          mv;
        logic          mfd;
        logic [BW-1:0] mpx;
        @(negedge clk);
        mv  = 1'b0;
        mfd = 1'b0;
        mpx = '0;
        if (mon_sel == 1) begin
            mv = o4_valid; mfd = o4_fd; mpx = o4_px;
        end else if (mon_sel == 2) begin
            mv = o14_valid; mfd = o14_fd; mpx = o14_px;
        end
        if (mon_sel != 0) begin
            if (mv) begin
                n_out++;
                if (mfd) n_fd++;
                if (exp_q.size() == 0) begin
                    checkNum("unexpected o_valid", int'(mv), 0);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("pooled pixel", mpx, e.bus);
                    checkNum("o_frame_done with pixel", int'(mfd), int'(e.fd));
                end
            end else begin
                checkNum("o_frame_done without o_valid", int'(mfd), 0);
            end
        end
        enable      = en;
        i_valid     = v;
        i_pixel_bus = bus;
    endtask

    // sel 1: 4x4 ramp with offset; sel 2: 14x14 pattern. stop_beats < 0 sends the whole frame.
    task automatic send_frame(int sel, int off, bit gapped, int stop_beats);
        int            w = (sel == 1) ? 4 : 14;
        int            h = (sel == 1) ? 4 : 14;
        int            beat = 0;
        exp_t          e;
        logic [BW-1:0] bus;
        for (int r = 0; r < h; r++) begin
            for (int c = 0; c < w; c++) begin
                if (beat == stop_beats) return;
                beat++;
                bus = (sel == 1) ? lanes(off + r * 4 + c, 16) : bus14(r, c);
                applyStimulus(1'b1, 1'b1, bus);
                if ((r % 2 == 1) && (c % 2 == 1)) begin
                    e.bus = (sel == 1) ? lanes(off + r * 4 + c, 16) : exp14(r, c);
                    e.fd  = (r == h - 1) && (c == w - 1);
                    exp_q.push_back(e);
                end
                if (gapped) applyStimulus(1'b1, 1'b0, lanes(32'h7FFF_FFFF, 0));
            end
        end
    endtask

    task automatic drain();
        repeat (3) applyStimulus(1'b1, 1'b0, '0);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst_n   = 1'b0;
        i_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        n_out = 0;
        n_fd  = 0;
    endtask

    initial begin
        tbl[0] = '{1, 2, 3, 4, 0, 4};
        tbl[1] = '{-5, -1, -9, -3, 0, -1};
        tbl[2] = '{7, 3, 5, 1, 100, 7};
        tbl[3] = '{32'sh8000_0000, 32'sh8000_0000, 32'sh8000_0001, 32'sh8000_0000, 0, 32'sh8000_0001};
        tbl[4] = '{32'sh7FFF_FFFF, -1, 0, 32'sh8000_0000, 0, 32'sh7FFF_FFFF};
        tbl[5] = '{-7, -7, -7, -7, 1, -7};
        tbl[6] = '{0, -1, 5, -9, 100, 5};
        tbl[7] = '{3, 8, -8, 2, 50, 8};

        rst_n       = 1'b1;
        enable      = 1'b1;
        i_valid     = 1'b0;
        i_pixel_bus = '0;
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checkNum("reset o_valid 2x2", int'(o2_valid), 0);
        checkOutput("reset o_pixel_bus 2x2", o2_px, '0);
        checkNum("reset o_valid 4x4", int'(o4_valid), 0);
        checkNum("reset o_frame_done 4x4", int'(o4_fd), 0);
        checkOutput("reset o_pixel_bus 14x14", o14_px, '0);
        rst_n = 1'b1;

        // Single 2x2 windows: exact one-cycle latency, signed compare, lane offsets, hold.
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 1'b1, lanes(tbl[i].p0, tbl[i].step));
            applyStimulus(1'b1, 1'b1, lanes(tbl[i].p1, tbl[i].step));
            applyStimulus(1'b1, 1'b1, lanes(tbl[i].p2, tbl[i].step));
            applyStimulus(1'b1, 1'b1, lanes(tbl[i].p3, tbl[i].step));
            checkNum("2x2 early o_valid", int'(o2_valid), 0);
            applyStimulus(1'b1, 1'b0, lanes(32'h7FFF_FFFF, 0));
            checkNum("2x2 o_valid", int'(o2_valid), 1);
            checkOutput("2x2 window max", o2_px, lanes(tbl[i].exp_max, tbl[i].step));
            checkNum("2x2 o_frame_done", int'(o2_fd), 1);
            applyStimulus(1'b1, 1'b0, lanes(-1, 0));
            checkNum("2x2 o_valid one cycle", int'(o2_valid), 0);
            checkOutput("2x2 pixel hold", o2_px, lanes(tbl[i].exp_max, tbl[i].step));
        end

        // 4x4 ramp followed immediately by a second frame offset by 100.
        pulse_reset();
        mon_sel = 1;
        send_frame(1, 0, 1'b0, -1);
        send_frame(1, 100, 1'b0, -1);
        drain();
        checkNum("4x4 back-to-back output count", n_out, 8);
        checkNum("4x4 back-to-back frame_done count", n_fd, 2);
        checkNum("4x4 back-to-back missing outputs", exp_q.size(), 0);

        // Soft clear mid-frame, then a fresh frame must restart at row 0, col 0.
        pulse_reset();
        send_frame(1, 0, 1'b0, 6);
        applyStimulus(1'b0, 1'b1, lanes(999, 0));
        send_frame(1, 200, 1'b0, -1);
        drain();
        checkNum("soft clear output count", n_out, 5);
        checkNum("soft clear frame_done count", n_fd, 1);
        checkNum("soft clear missing outputs", exp_q.size(), 0);

        // 14x14 with i_valid toggling every cycle.
        pulse_reset();
        mon_sel = 2;
        send_frame(2, 0, 1'b1, -1);
        drain();
        checkNum("gapped output count", n_out, 49);
        checkNum("gapped frame_done count", n_fd, 1);
        checkNum("gapped missing outputs", exp_q.size(), 0);

        // Reset partway into row 5, then a clean frame.
        pulse_reset();
        send_frame(2, 0, 1'b0, 14 * 5 + 3);
        checkNum("partial frame output count", n_out, 15);
        pulse_reset();
        checkNum("mid-frame reset o_valid", int'(o14_valid), 0);
        checkOutput("mid-frame reset o_pixel_bus", o14_px, '0);
        send_frame(2, 0, 1'b0, -1);
        drain();
        checkNum("post-reset output count", n_out, 49);
        checkNum("post-reset frame_done count", n_fd, 1);
        checkNum("post-reset missing outputs", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
